// File: rtl/cam_fifo_pkg.sv
// cam_fifo_pkg: shared types for the camera frame FIFO.
// FSM states, tag offsets above the data field, RAM word width.
package cam_fifo_pkg;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    DROP    = 2'd2
  } state_t;

  // tag bits sit directly above the data field: {sof, eol, data}
  localparam int EOL_BIT = 0;
  localparam int SOF_BIT = 1;

  function automatic int ram_word_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/cam_frame_fifo_if.sv
// cam_frame_fifo_if: camera pins plus consumer read side.
// CAM_FIFO_STATS_EN adds line_count/frame_count.
interface cam_frame_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 9
);
  logic              vsync;
  logic              href;
  logic [DATA_W-1:0] din;
  logic              rd;
  logic [DATA_W-1:0] dout;
  logic              dout_sof;
  logic              dout_eol;
  logic              dout_valid;
  logic              empty;
  logic              full;
  logic [DEPTH_LOG2:0] level;
  logic              overflow;
`ifdef CAM_FIFO_STATS_EN
  logic [11:0]       line_count;
  logic [15:0]       frame_count;

  modport master (
    output vsync, href, din, rd,
    input  dout, dout_sof, dout_eol, dout_valid,
    input  empty, full, level, overflow,
    input  line_count, frame_count
  );
  modport slave (
    input  vsync, href, din, rd,
    output dout, dout_sof, dout_eol, dout_valid,
    output empty, full, level, overflow,
    output line_count, frame_count
  );
`else
  modport master (
    output vsync, href, din, rd,
    input  dout, dout_sof, dout_eol, dout_valid,
    input  empty, full, level, overflow
  );
  modport slave (
    input  vsync, href, din, rd,
    output dout, dout_sof, dout_eol, dout_valid,
    output empty, full, level, overflow
  );
`endif
endinterface

// File: rtl/cam_fifo_ram.sv
// cam_fifo_ram: simple dual-port RAM, one write port,
// one synchronous read port whose register holds between reads.
module cam_fifo_ram #(
  parameter int W  = 10,
  parameter int AW = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [0:(1<<AW)-1];

  // write port
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // read port; cleared so dout starts at zero
  always_ff @(posedge clock) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/cam_frame_fifo.sv
// cam_frame_fifo: camera capture FIFO, sof/eol tags, frame drop on overflow.
// Optional macro CAM_FIFO_STATS_EN adds line_count and frame_count.
module cam_frame_fifo
  import cam_fifo_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int DEPTH_LOG2     = 9,
  parameter int VS_ACTIVE_HIGH = 1
) (
  input logic             clock,
  input logic             reset,
  cam_frame_fifo_if.slave bus
);
  localparam int W  = ram_word_w(DATA_W);
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH = LW'(1) << DEPTH_LOG2;
  localparam bit VS_POL = (VS_ACTIVE_HIGH != 0);

  state_t              state;
  logic                vs_q, vs_qq;
  logic [DATA_W-1:0]   stage;
  logic                stage_valid, armed;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]       level, level_nxt;
  logic                full, empty, overflow, dvalid;
  logic [W-1:0]        wdata, rdata;
  logic                vs_fall, vs_rise;
  logic                wr_try, wr_en, rd_en, wr_eol;

  // vs_q/vs_qq hold the blanking level; fall = blank->active
  assign vs_fall = vs_qq & ~vs_q;
  assign vs_rise = ~vs_qq & vs_q;
  assign wr_try  = (state == ACTIVE) & stage_valid;
  assign wr_en   = wr_try & ~full;
  assign rd_en   = bus.rd & ~empty;
  assign wr_eol  = vs_rise | ~bus.href;

  // pack the staged byte with its tags
  always_comb begin
    wdata = '0;
    wdata[DATA_W-1:0]     = stage;
    wdata[DATA_W+SOF_BIT] = armed;
    wdata[DATA_W+EOL_BIT] = wr_eol;
  end

  // occupancy after this edge
  always_comb begin
    level_nxt = level;
    if (wr_en & ~rd_en)      level_nxt = level + 1'b1;
    else if (rd_en & ~wr_en) level_nxt = level - 1'b1;
  end

  // capture FSM: vsync sync, staging, sof arming, overflow drop
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= WAIT_VS;
      vs_q        <= 1'b0;
      vs_qq       <= 1'b0;
      stage       <= '0;
      stage_valid <= 1'b0;
      armed       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      vs_q  <= bus.vsync ~^ VS_POL;
      vs_qq <= vs_q;
      if (wr_en) armed <= 1'b0;
      unique case (state)
        WAIT_VS: begin
          stage_valid <= 1'b0;
          if (vs_fall) begin
            state    <= ACTIVE;
            overflow <= 1'b0;
            armed    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            stage_valid <= 1'b0;
            state       <= WAIT_VS;
            if (wr_try & full) overflow <= 1'b1;
          end else if (wr_try & full) begin
            stage_valid <= 1'b0;
            overflow    <= 1'b1;
            state       <= DROP;
          end else begin
            stage_valid <= bus.href;
            if (bus.href) stage <= bus.din;
          end
        end
        DROP: begin
          stage_valid <= 1'b0;
          if (vs_rise) state <= WAIT_VS;
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

  // pointers, level, registered flags, read pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      dvalid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      level  <= level_nxt;
      full   <= (level_nxt == DEPTH);
      empty  <= (level_nxt == '0);
      dvalid <= rd_en;
    end
  end

  cam_fifo_ram #(
    .W  (W),
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign bus.dout       = rdata[DATA_W-1:0];
  assign bus.dout_sof   = rdata[DATA_W+SOF_BIT];
  assign bus.dout_eol   = rdata[DATA_W+EOL_BIT];
  assign bus.dout_valid = dvalid;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.level      = level;
  assign bus.overflow   = overflow;

`ifdef CAM_FIFO_STATS_EN
  logic [11:0] line_count;
  logic [15:0] frame_count;

  // per-frame line tally and completed-frame tally
  always_ff @(posedge clock) begin
    if (reset) begin
      line_count  <= '0;
      frame_count <= '0;
    end else begin
      if (state == WAIT_VS && vs_fall) line_count <= '0;
      else if (wr_en && wr_eol)        line_count <= line_count + 1'b1;
      if (state == ACTIVE && vs_rise)  frame_count <= frame_count + 1'b1;
    end
  end

  assign bus.line_count  = line_count;
  assign bus.frame_count = frame_count;
`endif
endmodule

// File: tb/tb_cam_frame_fifo.sv
// tb_cam_frame_fifo: randomized self-checking bench, DEPTH_LOG2=3.
// Expected words come from a queue model built from the frame/line rules.
module tb_cam_frame_fifo;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_frame_fifo_if #(.DATA_W(8), .DEPTH_LOG2(3)) bus();

  cam_frame_fifo #(
    .DATA_W(8), .DEPTH_LOG2(3), .VS_ACTIVE_HIGH(1)
  ) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int exp_frames = 0;
  logic [9:0] got[$];
  logic [9:0] exp[$];

  // collect every word the consumer receives
  always @(negedge clk)
    if (bus.dout_valid)
      got.push_back({bus.dout_sof, bus.dout_eol, bus.dout});

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t rnd_line(input int n);
    bq_t q;
    repeat (n) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic frame_start();
    bus.vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_end(input bit counted);
    bus.vsync = 1'b1;
    repeat (4) tick();
    if (counted) exp_frames++;
  endtask

  task automatic send_line(input bq_t b, input bit first,
                           input bit mdl, input bit rrd);
    foreach (b[i]) begin
      bus.href = 1'b1;
      bus.din  = b[i];
      if (rrd) bus.rd = 1'($urandom);
      if (mdl) exp.push_back({first && i == 0, i == b.size() - 1, b[i]});
      tick();
    end
    bus.href = 1'b0;
    bus.rd   = 1'b0;
    tick();
  endtask

  task automatic drain();
    bus.rd = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.empty) break;
    end
    bus.rd = 1'b0;
    tick();
    tick();
    total++;
    if (bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL drain_timeout empty=%b want=1", bus.empty);
    end
  endtask

  task automatic test_reset();
    bq_t q;
    bus.vsync = 1'b1; bus.href = 1'b0; bus.din = '0; bus.rd = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total += 6;
    if (bus.empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b want=1", bus.empty); end
    if (bus.full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b want=0", bus.full); end
    if (bus.level !== 4'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", bus.level); end
    if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", bus.overflow); end
    if (bus.dout !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h want=00", bus.dout); end
    if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL rst_dvalid got=%b want=0", bus.dout_valid); end
    frame_start();
    q = {8'hAA, 8'h55};
    send_line(q, 1'b1, 1'b0, 1'b0);
    bus.rd = 1'b1; tick(); bus.rd = 1'b0; tick();
    total++;
    if (bus.dout !== 8'hAA) begin bad++; $display("FAIL pre_rst_dout got=%h want=aa", bus.dout); end
    bus.href = 1'b1; bus.din = 8'($urandom); tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    got.delete(); exp.delete(); exp_frames = 0;
    total += 5;
    if (bus.empty !== 1'b1) begin bad++; $display("FAIL mid_rst_empty got=%b want=1", bus.empty); end
    if (bus.level !== 4'd0) begin bad++; $display("FAIL mid_rst_level got=%0d want=0", bus.level); end
    if (bus.overflow !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf got=%b want=0", bus.overflow); end
    if (bus.dout !== 8'h00) begin bad++; $display("FAIL mid_rst_dout got=%h want=00", bus.dout); end
    if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_dvalid got=%b want=0", bus.dout_valid); end
    repeat (4) begin bus.din = 8'($urandom); tick(); end
    bus.href = 1'b0;
    repeat (2) tick();
    total++;
    if (bus.level !== 4'd0) begin bad++; $display("FAIL ignore_level got=%0d want=0", bus.level); end
    frame_end(1'b0);
    frame_start();
    send_line(rnd_line(2), 1'b1, 1'b1, 1'b0);
    total++;
    if (bus.level !== 4'd2) begin bad++; $display("FAIL post_rst_level got=%0d want=2", bus.level); end
    frame_end(1'b1);
    drain();
    total++;
    if (got.size() !== exp.size()) begin bad++; $display("FAIL post_rst_count got=%0d want=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL post_rst_word%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
  endtask

  task automatic test_single_line();
    bq_t q;
    frame_start();
    got.delete(); exp.delete();
    q = {8'h68, 8'h6F, 8'h6C, 8'h61};
    send_line(q, 1'b1, 1'b1, 1'b0);
    total++;
    if (bus.level !== 4'd4) begin bad++; $display("FAIL single_level got=%0d want=4", bus.level); end
    frame_end(1'b1);
    drain();
    total++;
    if (got.size() !== 4) begin bad++; $display("FAIL single_pulses got=%0d want=4", got.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL single_word%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
  endtask

  task automatic test_two_lines();
    frame_start();
    got.delete(); exp.delete();
    send_line(rnd_line(3), 1'b1, 1'b1, 1'b0);
    send_line(rnd_line(2), 1'b0, 1'b1, 1'b0);
    frame_end(1'b1);
    drain();
    total++;
    if (got.size() !== 5) begin bad++; $display("FAIL two_count got=%0d want=5", got.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL two_word%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bq_t q;
    frame_start();
    got.delete(); exp.delete();
    q = rnd_line(12);
    send_line(q, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) exp.push_back({i == 0, 1'b0, q[i]});
    total += 3;
    if (bus.level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d want=8", bus.level); end
    if (bus.full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b want=1", bus.full); end
    if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", bus.overflow); end
    frame_end(1'b0);
    total++;
    if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", bus.overflow); end
    drain();
    total++;
    if (got.size() !== 8) begin bad++; $display("FAIL ovf_count got=%0d want=8", got.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL ovf_word%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
    got.delete(); exp.delete();
    frame_start();
    total++;
    if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", bus.overflow); end
    send_line(rnd_line(3), 1'b1, 1'b1, 1'b0);
    frame_end(1'b1);
    drain();
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL ovf_next_word%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    frame_start();
    got.delete(); exp.delete();
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      bus.href = 1'b1;
      bus.din  = b;
      bus.rd   = (i >= 1);
      exp.push_back({i == 0, i == 19, b});
      tick();
      total += 2;
      if (bus.level > 4'd2) begin bad++; $display("FAIL wrap_level%0d got=%0d want<=2", i, bus.level); end
      if (bus.full !== 1'b0) begin bad++; $display("FAIL wrap_full%0d got=%b want=0", i, bus.full); end
    end
    bus.href = 1'b0;
    tick();
    drain();
    frame_end(1'b1);
    total++;
    if (got.size() !== 20) begin bad++; $display("FAIL wrap_count got=%0d want=20", got.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL wrap_word%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
  endtask

  task automatic test_vsync_midline();
    bq_t q;
    frame_start();
    got.delete(); exp.delete();
    q = rnd_line(6);
    for (int i = 0; i < 6; i++) begin
      bus.href = 1'b1;
      bus.din  = q[i];
      if (i == 3) bus.vsync = 1'b1;
      if (i <= 3) exp.push_back({i == 0, i == 3, q[i]});
      tick();
    end
    bus.href = 1'b0;
    repeat (3) tick();
    exp_frames++;
    total++;
    if (bus.level !== 4'd4) begin bad++; $display("FAIL mid_level got=%0d want=4", bus.level); end
`ifdef CAM_FIFO_STATS_EN
    total += 2;
    if (bus.frame_count !== 16'(exp_frames)) begin
      bad++; $display("FAIL mid_frames got=%0d want=%0d", bus.frame_count, exp_frames);
    end
    if (bus.line_count !== 12'd1) begin bad++; $display("FAIL mid_lines got=%0d want=1", bus.line_count); end
`endif
    drain();
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL mid_word%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      frame_start();
      got.delete(); exp.delete();
      for (int l = 0; l < 2; l++)
        send_line(rnd_line($urandom_range(1, 4)), l == 0, 1'b1, 1'b1);
      frame_end(1'b1);
      drain();
      total++;
      if (got.size() !== exp.size()) begin
        bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", f, got.size(), exp.size());
      end
      foreach (exp[i]) begin
        total++;
        if (i >= got.size() || got[i] !== exp[i]) begin
          bad++; $display("FAIL rnd%0d_word%0d got=%h want=%h", f, i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
        end
      end
`ifdef CAM_FIFO_STATS_EN
      total++;
      if (bus.frame_count !== 16'(exp_frames)) begin
        bad++; $display("FAIL rnd%0d_frames got=%0d want=%0d", f, bus.frame_count, exp_frames);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_two_lines();
    test_overflow();
    test_wrap();
    test_vsync_midline();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
